sl_preceptron_mem_arbiter: RTL and testbench
============================================

SL_PRECEPTRON_MEM_ARBITER -- requirements
Module: sl_preceptron_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SRAM data width (weights).
REQ-002 Parameter ADDR_WIDTH, default 16, SRAM address width.
REQ-003 Parameter WAIT_CNT_WIDTH, default 8, width of host wait counter.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port host_req  input  1  host access request; held until host_ack.
REQ-007 Port host_wen  input  1  1 = write, 0 = read; sampled with host_req.
REQ-008 Port host_addr  input  ADDR_WIDTH  host address.
REQ-009 Port host_wdata  input  DATA_WIDTH  host write data.
REQ-010 Port host_ack  output  1  one-cycle pulse: request accepted.
REQ-011 Port host_rdata  output  DATA_WIDTH  host read data; holds last value.
REQ-012 Port host_rvalid  output  1  one-cycle pulse: host_rdata updated.
REQ-013 Port mac_start  input  1  pulse: MAC requests exclusive SRAM lock.
REQ-014 Port mac_done  input  1  pulse: MAC releases lock.
REQ-015 Ports mac_wen, mac_ren (1), mac_addr (ADDR_WIDTH), mac_wdata (DATA_WIDTH)  input  MAC SRAM bus.
REQ-016 Port mac_rdata  output  DATA_WIDTH  mem_rdata while lock=1, else 0.
REQ-017 Ports mem_wen, mem_ren (1), mem_addr (ADDR_WIDTH), mem_wdata (DATA_WIDTH)  output  SRAM bus.
REQ-018 Port mem_rdata  input  DATA_WIDTH  SRAM read data, valid cycle after mem_ren.
REQ-019 Port lock  output  1  1 while FSM in LOCK.
REQ-020 Port proto_err  output  1  sticky protocol-error flag.
REQ-021 Port host_wait_cnt  output  WAIT_CNT_WIDTH  cycles current host_req waited unacked.

Function
REQ-022 FSM states IDLE, HOST, RDWAIT, LOCK, UNLOCK; reset state IDLE.
REQ-023 start_pend flag set on mac_start in any state except LOCK; cleared on entering LOCK.
REQ-024 IDLE: mac_start or start_pend -> LOCK (MAC priority over host_req); else host_req -> host_ack=1, capture wen/addr/wdata into holding register, -> HOST.
REQ-025 HOST (one cycle): drive mem bus from holding register (mem_wen=wen, mem_ren=~wen); write -> IDLE, read -> RDWAIT.
REQ-026 RDWAIT (one cycle): host_rdata <= mem_rdata, host_rvalid=1 next cycle; -> IDLE.
REQ-027 Host latency: ack at cycle T, mem access T+1, read host_rvalid at T+3 (registered); next host_ack earliest T+2 (write) or T+3 (read).
REQ-028 LOCK: mem_* = mac_* combinationally; host_ack never asserted; mac_done -> UNLOCK.
REQ-029 UNLOCK (one cycle): mem_wen=mem_ren=0, lock=0; -> IDLE (re-enters LOCK next cycle if start_pend).
REQ-030 mac_start and mac_done same cycle in LOCK: done wins, start ignored, proto_err set.
REQ-031 mac_start in LOCK, or mac_done outside LOCK: ignored, proto_err set; proto_err clears only on reset.
REQ-032 Outside HOST and LOCK, mem_wen, mem_ren, mem_addr, mem_wdata are 0.
REQ-033 host_wait_cnt increments each cycle host_req=1 and host_ack=0, saturates at all-ones, clears on host_ack or host_req=0.
REQ-034 mac_start while in HOST/RDWAIT: in-flight host access completes (incl. rvalid), then LOCK.

Reset
REQ-035 rst=1 immediately forces IDLE, clears start_pend, holding register, host_rdata, proto_err, host_wait_cnt; all outputs 0 regardless of clk.
REQ-036 Reset mid-access drops in-flight host read (no host_rvalid) and releases lock.

Verification
REQ-037 Host write addr 0x0010 data 0xA5 in IDLE -> host_ack T, mem_wen=1 addr 0x0010 wdata 0xA5 at T+1, back IDLE T+2.
REQ-038 Host read 0x0010 after REQ-037 -> mem_ren T+1, host_rvalid=1 host_rdata=0xA5 at T+3.
REQ-039 mac_start and host_req same cycle in IDLE -> lock=1 next cycle, no host_ack; host_wait_cnt counts up; mac_done -> UNLOCK, then host_ack within 2 cycles, counter cleared.
REQ-040 mac_start during host read's HOST cycle -> host_rvalid still delivered, lock=1 the cycle after RDWAIT.
REQ-041 mac_done in IDLE, then mac_start+mac_done together in LOCK -> proto_err=1 and stays 1; lock drops via UNLOCK.
REQ-042 rst asserted mid-LOCK between clock edges -> lock=0, all mem_* 0 immediately; host_req 300 cycles under lock -> host_wait_cnt saturates at 255.

Source files
------------

// File: rtl/sl_preceptron_mem_arbiter.sv
// SRAM arbiter shared by a host port (single, acknowledged accesses) and the perceptron MAC,
// which may take an exclusive lock on the SRAM bus between mac_start and mac_done.
module sl_preceptron_mem_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_req,
    input  logic                      host_wen,
    input  logic [ADDR_WIDTH-1:0]     host_addr,
    input  logic [DATA_WIDTH-1:0]     host_wdata,
    output logic                      host_ack,
    output logic [DATA_WIDTH-1:0]     host_rdata,
    output logic                      host_rvalid,
    input  logic                      mac_start,
    input  logic                      mac_done,
    input  logic                      mac_wen,
    input  logic                      mac_ren,
    input  logic [ADDR_WIDTH-1:0]     mac_addr,
    input  logic [DATA_WIDTH-1:0]     mac_wdata,
    output logic [DATA_WIDTH-1:0]     mac_rdata,
    output logic                      mem_wen,
    output logic                      mem_ren,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      lock,
    output logic                      proto_err,
    output logic [WAIT_CNT_WIDTH-1:0] host_wait_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOST   = 3'd1,
        S_RDWAIT = 3'd2,
        S_LOCK   = 3'd3,
        S_UNLOCK = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic                      start_pend_q, start_pend_d;
    logic                      hold_wen_q, hold_wen_d;
    logic [ADDR_WIDTH-1:0]     hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0]     hold_wdata_q, hold_wdata_d;
    logic [DATA_WIDTH-1:0]     host_rdata_q, host_rdata_d;
    logic                      host_rvalid_q, host_rvalid_d;
    logic                      proto_err_q, proto_err_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                      ack_s;
    logic                      want_lock_s;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_pend_q  <= 1'b0;
            hold_wen_q    <= 1'b0;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            proto_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            start_pend_q  <= start_pend_d;
            hold_wen_q    <= hold_wen_d;
            hold_addr_q   <= hold_addr_d;
            hold_wdata_q  <= hold_wdata_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            proto_err_q   <= proto_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Next-state logic, SRAM bus steering and host bookkeeping.
    always_comb begin
        state_d       = state_q;
        start_pend_d  = start_pend_q;
        hold_wen_d    = hold_wen_q;
        hold_addr_d   = hold_addr_q;
        hold_wdata_d  = hold_wdata_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        proto_err_d   = proto_err_q;
        wait_cnt_d    = wait_cnt_q;
        ack_s         = 1'b0;
        mem_wen       = 1'b0;
        mem_ren       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        want_lock_s   = mac_start | start_pend_q;

        if (mac_start && (state_q != S_LOCK)) begin
            start_pend_d = 1'b1;
        end else begin
            start_pend_d = start_pend_d;
        end

        if ((mac_start && (state_q == S_LOCK)) || (mac_done && (state_q != S_LOCK))) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_d;
        end

        case (state_q)
            S_IDLE: begin
                if (want_lock_s) begin
                    state_d = S_LOCK;
                end else if (host_req) begin
                    ack_s        = 1'b1;
                    hold_wen_d   = host_wen;
                    hold_addr_d  = host_addr;
                    hold_wdata_d = host_wdata;
                    state_d      = S_HOST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOST: begin
                mem_wen   = hold_wen_q;
                mem_ren   = ~hold_wen_q;
                mem_addr  = hold_addr_q;
                mem_wdata = hold_wdata_q;
                // A pending lock is granted as soon as the host access has finished.
                if (!hold_wen_q) begin
                    state_d = S_RDWAIT;
                end else if (want_lock_s) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RDWAIT: begin
                host_rdata_d  = mem_rdata;
                host_rvalid_d = 1'b1;
                if (want_lock_s) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                mem_wen   = mac_wen;
                mem_ren   = mac_ren;
                mem_addr  = mac_addr;
                mem_wdata = mac_wdata;
                if (mac_done) begin
                    state_d = S_UNLOCK;
                end else begin
                    state_d = S_LOCK;
                end
            end
            S_UNLOCK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_LOCK) && (state_q != S_LOCK)) begin
            start_pend_d = 1'b0;
        end else begin
            start_pend_d = start_pend_d;
        end

        if (!host_req || ack_s) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != {WAIT_CNT_WIDTH{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // host_ack is combinational, so it must be gated to stay low while reset is held.
    assign host_ack      = ack_s & ~rst;
    assign host_rdata    = host_rdata_q;
    assign host_rvalid   = host_rvalid_q;
    assign lock          = (state_q == S_LOCK);
    assign mac_rdata     = lock ? mem_rdata : '0;
    assign proto_err     = proto_err_q;
    assign host_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_sl_preceptron_mem_arbiter.sv
// Scoreboard bench for sl_preceptron_mem_arbiter: an SRAM model, a reference memory array,
// directed scenarios plus randomized host/MAC traffic.
module tb_sl_preceptron_mem_arbiter;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_wen, host_ack, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          mac_start, mac_done, mac_wen, mac_ren;
    logic [AW-1:0] mac_addr;
    logic [DW-1:0] mac_wdata, mac_rdata;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          lock, proto_err;
    logic [CW-1:0] host_wait_cnt;

    sl_preceptron_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mac_start(mac_start), .mac_done(mac_done), .mac_wen(mac_wen), .mac_ren(mac_ren),
        .mac_addr(mac_addr), .mac_wdata(mac_wdata), .mac_rdata(mac_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lock(lock), .proto_err(proto_err), .host_wait_cnt(host_wait_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: synchronous write, read data registered one cycle after mem_ren.
    logic [DW-1:0] sram [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
    end

    logic [DW-1:0] ref_mem [256] = '{default: 8'h00};

    typedef struct packed {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int last_ack_cyc = -10;
    int done_cyc = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endfunction

    // Monitor: read-data scoreboard and per-cycle bus ownership checks.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (host_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("host_rdata", 64'(host_rdata), 64'(e.data));
                check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (lock) begin
            check("lock_bus", 64'({mem_wen, mem_ren, mem_addr, mem_wdata}),
                  64'({mac_wen, mac_ren, mac_addr, mac_wdata}));
            check("lock_no_ack", 64'(host_ack), 64'd0);
            check("lock_mac_rdata", 64'(mac_rdata), 64'(mem_rdata));
        end else if (cyc != last_ack_cyc + 1) begin
            check("idle_bus", 64'({mem_wen, mem_ren, mem_addr, mem_wdata}), 64'd0);
            check("mac_rdata_zero", 64'(mac_rdata), 64'd0);
        end
    end

    task automatic host_op(input bit wen, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_imm);
        int waited;
        bit got;
        exp_t e;
        @(negedge clk);
        host_req = 1'b1; host_wen = wen; host_addr = a; host_wdata = d;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 600) begin
            #1;
            check("wait_cnt", 64'(host_wait_cnt), 64'((waited > 255) ? 255 : waited));
            if (host_ack) got = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        if (!got) begin
            check("ack_timeout", 64'd0, 64'd1);
            host_req = 1'b0;
            return;
        end
        if (expect_imm) check("ack_latency", 64'(waited), 64'd0);
        last_ack_cyc = cyc;
        if (wen) ref_mem[a[7:0]] = d;
        else begin
            e.data = ref_mem[a[7:0]];
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        check("host_bus", 64'({mem_wen, mem_ren, mem_addr, mem_wdata}), 64'({wen, !wen, a, d}));
        host_req = 1'b0; host_wen = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic mac_session(input int nops, input int exp_lat, input bit start_with_done);
        int lat;
        bit pend;
        logic [DW-1:0] rexp;
        @(negedge clk);
        mac_start = 1'b1;
        @(negedge clk);
        mac_start = 1'b0;
        lat = 1;
        while (!lock && lat < 800) begin
            @(negedge clk);
            lat++;
        end
        if (!lock) begin
            check("lock_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_lat >= 0) check("lock_latency", 64'(lat), 64'(exp_lat));
        rexp = '0;
        for (int i = 0; i < nops; i++) begin
            mac_wen = 1'b0; mac_ren = 1'b0;
            mac_addr = AW'($urandom_range(0, 31));
            mac_wdata = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                mac_wen = 1'b1;
                ref_mem[mac_addr[7:0]] = mac_wdata;
            end else begin
                mac_ren = 1'b1;
                rexp = ref_mem[mac_addr[7:0]];
            end
            pend = mac_ren;
            @(negedge clk);
            if (pend) check("mac_read", 64'(mac_rdata), 64'(rexp));
        end
        mac_wen = 1'b0; mac_ren = 1'b0; mac_addr = '0; mac_wdata = '0;
        mac_done = 1'b1; mac_start = start_with_done; done_cyc = cyc;
        @(negedge clk);
        mac_done = 1'b0; mac_start = 1'b0;
        check("unlock", 64'(lock), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        host_req = 1'b1; host_wen = 1'b0; host_addr = 16'h0010; host_wdata = 8'h00;
        mac_start = 1'b0; mac_done = 1'b0; mac_wen = 1'b0; mac_ren = 1'b0;
        mac_addr = '0; mac_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 64'({lock, mem_wen, mem_ren, mem_addr, mem_wdata, host_ack, host_rvalid,
              host_rdata, proto_err, host_wait_cnt, mac_rdata}), 64'd0);
        @(negedge clk);
        rst = 1'b0; host_req = 1'b0;

        // Directed host write then read of the same address.
        host_op(1'b1, 16'h0010, 8'hA5, 1'b1);
        host_op(1'b0, 16'h0010, 8'h00, 1'b1);

        // MAC and host request in the same IDLE cycle: MAC first, host afterwards.
        repeat (3) @(negedge clk);
        fork
            host_op(1'b1, 16'h0004, 8'h3C, 1'b0);
            mac_session(4, 1, 1'b0);
        join
        check("ack_after_unlock", 64'(last_ack_cyc), 64'(done_cyc + 2));
        check("wait_cnt_cleared", 64'(host_wait_cnt), 64'd0);

        // mac_start during a read's HOST cycle: read completes, lock right after.
        repeat (3) @(negedge clk);
        fork
            host_op(1'b0, 16'h0010, 8'h00, 1'b1);
            begin
                @(negedge clk);
                mac_session(2, 2, 1'b0);
            end
        join

        // Randomized mixed traffic.
        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;
            int nops;
            kind = $urandom_range(0, 3);
            ra = AW'($urandom_range(0, 31));
            rd = DW'($urandom);
            nops = $urandom_range(0, 6);
            case (kind)
                0: host_op(1'b1, ra, rd, 1'b0);
                1: host_op(1'b0, ra, rd, 1'b0);
                2: mac_session(nops, -1, 1'b0);
                default: begin
                    fork
                        host_op(rd[0], ra, rd, 1'b0);
                        mac_session(nops, 1, 1'b0);
                    join
                end
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("proto_clean", 64'(proto_err), 64'd0);

        // Protocol errors: mac_done outside LOCK, then start+done together in LOCK.
        mac_done = 1'b1;
        @(negedge clk);
        mac_done = 1'b0;
        check("proto_done_idle", 64'(proto_err), 64'd1);
        mac_session(2, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("no_relock", 64'(lock), 64'd0);
        check("proto_sticky", 64'(proto_err), 64'd1);

        // Host request held through a long lock: wait counter saturates.
        fork
            host_op(1'b1, 16'h0021, 8'h77, 1'b0);
            mac_session(300, 1, 1'b0);
        join

        // Asynchronous reset in the middle of a lock.
        repeat (2) @(negedge clk);
        mac_start = 1'b1; host_req = 1'b1; host_wen = 1'b0; host_addr = 16'h0005;
        @(negedge clk);
        mac_start = 1'b0;
        repeat (3) @(negedge clk);
        check("lock_held", 64'(lock), 64'd1);
        check("wait_under_lock", 64'(host_wait_cnt), 64'd4);
        mac_wen = 1'b1; mac_ren = 1'b1; mac_addr = 16'h0033; mac_wdata = 8'h5A;
        #3 rst = 1'b1;
        #1;
        check("midlock_reset", 64'({lock, mem_wen, mem_ren, mem_addr, mem_wdata, host_ack, host_rvalid,
              host_rdata, proto_err, host_wait_cnt, mac_rdata}), 64'd0);
        @(negedge clk);
        mac_wen = 1'b0; mac_ren = 1'b0; mac_addr = '0; mac_wdata = '0;
        host_req = 1'b0; host_addr = '0;
        exp_q.delete();
        rst = 1'b0;

        // Reset during a host read drops it: no rvalid may follow.
        @(negedge clk);
        host_req = 1'b1; host_wen = 1'b0; host_addr = 16'h0010;
        #1;
        check("drop_ack", 64'(host_ack), 64'd1);
        last_ack_cyc = cyc;
        @(negedge clk);
        host_req = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("drop_rvalid", 64'(host_rvalid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("drop_rdata", 64'(host_rdata), 64'd0);

        // Recovery after reset.
        host_op(1'b1, 16'h0020, 8'hC3, 1'b1);
        host_op(1'b0, 16'h0020, 8'h00, 1'b1);
        repeat (6) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
